axis_rx_frame_stats: RTL and testbench

AXIS_RX_FRAME_STATS -- requirements
Module: axis_rx_frame_stats

---
 rtl/eth_stats_pkg.sv | 46 ++++
 rtl/eth_stats_counter.sv | 43 ++++
 rtl/axis_rx_frame_stats.sv | 129 ++++++++++++
 tb/tb_axis_rx_frame_stats.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_stats_pkg.sv
// Shared types and constants for the receive frame statistics block.
// Frame classes, FCS length, and histogram bin boundaries (used with AXIS_RX_FRAME_STATS_HIST_EN).
package eth_stats_pkg;

   typedef enum logic [2:0] {GOOD, RUNT, OVERSIZE, FCS_ERR, PHY_ERR} frame_class_e;
   typedef enum logic {IDLE, IN_FRAME} rx_state_e;

   localparam int unsigned FCS_LEN    = 4;
   localparam int unsigned LEN_WIDTH  = 16;
   localparam int unsigned FLEN_WIDTH = 17;
   localparam int unsigned HIST_BINS  = 6;

   // Inclusive lower bound of each histogram bin; bin 0 holds only 64-byte frames.
   localparam int unsigned HIST_LO_64   = 64;
   localparam int unsigned HIST_LO_65   = 65;
   localparam int unsigned HIST_LO_128  = 128;
   localparam int unsigned HIST_LO_256  = 256;
   localparam int unsigned HIST_LO_512  = 512;
   localparam int unsigned HIST_LO_1024 = 1024;

   function automatic frame_class_e classify(input logic phy_err, input logic fcs_err,
                                             input logic [FLEN_WIDTH-1:0] len,
                                             input logic [FLEN_WIDTH-1:0] min_len,
                                             input logic [FLEN_WIDTH-1:0] max_len);
      frame_class_e cls;
      if (phy_err)            cls = PHY_ERR;
      else if (fcs_err)       cls = FCS_ERR;
      else if (len < min_len) cls = RUNT;
      else if (len > max_len) cls = OVERSIZE;
      else                    cls = GOOD;
      return cls;
   endfunction

   function automatic logic [HIST_BINS-1:0] hist_onehot(input logic [FLEN_WIDTH-1:0] len);
      logic [HIST_BINS-1:0] oh;
      oh = '0;
      if (len >= FLEN_WIDTH'(HIST_LO_1024))     oh[5] = 1'b1;
      else if (len >= FLEN_WIDTH'(HIST_LO_512)) oh[4] = 1'b1;
      else if (len >= FLEN_WIDTH'(HIST_LO_256)) oh[3] = 1'b1;
      else if (len >= FLEN_WIDTH'(HIST_LO_128)) oh[2] = 1'b1;
      else if (len >= FLEN_WIDTH'(HIST_LO_65))  oh[1] = 1'b1;
      else if (len >= FLEN_WIDTH'(HIST_LO_64))  oh[0] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/eth_stats_counter.sv
// One saturating statistics counter with snapshot register and clear-after-capture.
module eth_stats_counter #(
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned INC_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   input  logic [INC_WIDTH-1:0] inc_amt,
   input  logic                 snapshot,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] stat
);

   localparam int unsigned SUM_WIDTH = ((CNT_WIDTH > INC_WIDTH) ? CNT_WIDTH : INC_WIDTH) + 1;

   logic [CNT_WIDTH-1:0] live;
   logic [CNT_WIDTH-1:0] live_next_c;
   logic [SUM_WIDTH-1:0] sum_c;

   // Wide add so the saturation test sees the true sum.
   always_comb begin
      sum_c       = SUM_WIDTH'(live) + SUM_WIDTH'(inc_amt);
      live_next_c = live;
      if (inc) begin
         if (sum_c > SUM_WIDTH'({CNT_WIDTH{1'b1}})) live_next_c = '1;
         else                                        live_next_c = CNT_WIDTH'(sum_c);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live <= '0;
         stat <= '0;
      end else if (snapshot) begin
         stat <= live_next_c;
         live <= clear ? '0 : live_next_c;
      end else begin
         live <= live_next_c;
      end
   end

endmodule

// File: rtl/axis_rx_frame_stats.sv
// AXI-Stream receive frame classifier and statistics counters with snapshot publishing.
// Define AXIS_RX_FRAME_STATS_HIST_EN to add the good-frame length histogram outputs.
module axis_rx_frame_stats
   import eth_stats_pkg::*;
#(
   parameter int unsigned CNT_WIDTH     = 32,
   parameter int unsigned MIN_FRAME_LEN = 64,
   parameter int unsigned MAX_FRAME_LEN = 1518,
   parameter int unsigned FCS_IN_STREAM = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   input  logic [2:0]           s_axis_tuser,
   input  logic                 snapshot,
   input  logic                 clear_on_snapshot,
   output logic                 stat_valid,
   output logic [CNT_WIDTH-1:0] stat_good_frames,
   output logic [CNT_WIDTH-1:0] stat_good_bytes,
   output logic [CNT_WIDTH-1:0] stat_fcs_err_frames,
   output logic [CNT_WIDTH-1:0] stat_phy_err_frames,
   output logic [CNT_WIDTH-1:0] stat_runt_frames,
   output logic [CNT_WIDTH-1:0] stat_oversize_frames
`ifdef AXIS_RX_FRAME_STATS_HIST_EN
   ,
   output logic [CNT_WIDTH-1:0] stat_hist_64,
   output logic [CNT_WIDTH-1:0] stat_hist_65_127,
   output logic [CNT_WIDTH-1:0] stat_hist_128_255,
   output logic [CNT_WIDTH-1:0] stat_hist_256_511,
   output logic [CNT_WIDTH-1:0] stat_hist_512_1023,
   output logic [CNT_WIDTH-1:0] stat_hist_1024_max
`endif
);

   localparam int unsigned FCS_ADD = (FCS_IN_STREAM != 0) ? 0 : FCS_LEN;

   rx_state_e              state_q, state_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   cur_len_c;
   logic [FLEN_WIDTH-1:0]  frame_len_c;
   frame_class_e           class_c;
   logic                   done_c;
   logic                   unused_c;

   assign unused_c = ^{s_axis_tdata, s_axis_tuser[2]};

   // Beat count including the current beat; a beat seen in IDLE always starts at 1.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cur_len_c   = '0;
      if (state_q == IDLE)          cur_len_c = LEN_WIDTH'(1);
      else if (len_q == '1)         cur_len_c = len_q;
      else                          cur_len_c = len_q + LEN_WIDTH'(1);
      frame_len_c = FLEN_WIDTH'(cur_len_c) + FLEN_WIDTH'(FCS_ADD);
      done_c      = s_axis_tvalid & s_axis_tlast;
      class_c     = classify(s_axis_tuser[0], s_axis_tuser[1], frame_len_c,
                             FLEN_WIDTH'(MIN_FRAME_LEN), FLEN_WIDTH'(MAX_FRAME_LEN));
      if (s_axis_tvalid) begin
         if (s_axis_tlast) begin
            state_d = IDLE;
            len_d   = '0;
         end else begin
            state_d = IN_FRAME;
            len_d   = cur_len_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         stat_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         stat_valid <= snapshot;
      end
   end

   eth_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_good (
      .clk(clk), .rst_n(rst_n), .inc(done_c && class_c == GOOD), .inc_amt(1'b1),
      .snapshot(snapshot), .clear(clear_on_snapshot), .stat(stat_good_frames));

   eth_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(FLEN_WIDTH)) u_bytes (
      .clk(clk), .rst_n(rst_n), .inc(done_c && class_c == GOOD), .inc_amt(frame_len_c),
      .snapshot(snapshot), .clear(clear_on_snapshot), .stat(stat_good_bytes));

   eth_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_fcs (
      .clk(clk), .rst_n(rst_n), .inc(done_c && class_c == FCS_ERR), .inc_amt(1'b1),
      .snapshot(snapshot), .clear(clear_on_snapshot), .stat(stat_fcs_err_frames));

   eth_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_phy (
      .clk(clk), .rst_n(rst_n), .inc(done_c && class_c == PHY_ERR), .inc_amt(1'b1),
      .snapshot(snapshot), .clear(clear_on_snapshot), .stat(stat_phy_err_frames));

   eth_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_runt (
      .clk(clk), .rst_n(rst_n), .inc(done_c && class_c == RUNT), .inc_amt(1'b1),
      .snapshot(snapshot), .clear(clear_on_snapshot), .stat(stat_runt_frames));

   eth_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_over (
      .clk(clk), .rst_n(rst_n), .inc(done_c && class_c == OVERSIZE), .inc_amt(1'b1),
      .snapshot(snapshot), .clear(clear_on_snapshot), .stat(stat_oversize_frames));

`ifdef AXIS_RX_FRAME_STATS_HIST_EN
   logic [HIST_BINS-1:0] hist_oh_c;
   logic [CNT_WIDTH-1:0] hist_stat [HIST_BINS];

   assign hist_oh_c = hist_onehot(frame_len_c);

   for (genvar i = 0; i < HIST_BINS; i++) begin : g_hist
      eth_stats_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_hist (
         .clk(clk), .rst_n(rst_n), .inc(done_c && class_c == GOOD && hist_oh_c[i]),
         .inc_amt(1'b1), .snapshot(snapshot), .clear(clear_on_snapshot),
         .stat(hist_stat[i]));
   end

   assign stat_hist_64       = hist_stat[0];
   assign stat_hist_65_127   = hist_stat[1];
   assign stat_hist_128_255  = hist_stat[2];
   assign stat_hist_256_511  = hist_stat[3];
   assign stat_hist_512_1023 = hist_stat[4];
   assign stat_hist_1024_max = hist_stat[5];
`endif

endmodule

// File: tb/tb_axis_rx_frame_stats.sv
// Scoreboard bench for axis_rx_frame_stats: a 32-bit and a 4-bit counter instance share stimulus.
module tb_axis_rx_frame_stats;

   typedef struct {
      int good, bytes, fcs, phy, runt, over;
      int h0, h1, h2, h3, h4, h5;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tdata;
   logic       tvalid, tlast, snapshot, clear;
   logic [2:0] tuser;
   logic        a_valid, b_valid;
   logic [31:0] a_good, a_bytes, a_fcs, a_phy, a_runt, a_over;
   logic [3:0]  b_good, b_bytes, b_fcs, b_phy, b_runt, b_over;
`ifdef AXIS_RX_FRAME_STATS_HIST_EN
   logic [31:0] a_h0, a_h1, a_h2, a_h3, a_h4, a_h5;
   logic [3:0]  b_h0, b_h1, b_h2, b_h3, b_h4, b_h5;
`endif

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb[$];
   exp_t e0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_rx_frame_stats dut (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser), .snapshot(snapshot),
      .clear_on_snapshot(clear), .stat_valid(a_valid), .stat_good_frames(a_good),
      .stat_good_bytes(a_bytes), .stat_fcs_err_frames(a_fcs), .stat_phy_err_frames(a_phy),
      .stat_runt_frames(a_runt), .stat_oversize_frames(a_over)
`ifdef AXIS_RX_FRAME_STATS_HIST_EN
      , .stat_hist_64(a_h0), .stat_hist_65_127(a_h1), .stat_hist_128_255(a_h2),
      .stat_hist_256_511(a_h3), .stat_hist_512_1023(a_h4), .stat_hist_1024_max(a_h5)
`endif
   );

   axis_rx_frame_stats #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser), .snapshot(snapshot),
      .clear_on_snapshot(clear), .stat_valid(b_valid), .stat_good_frames(b_good),
      .stat_good_bytes(b_bytes), .stat_fcs_err_frames(b_fcs), .stat_phy_err_frames(b_phy),
      .stat_runt_frames(b_runt), .stat_oversize_frames(b_over)
`ifdef AXIS_RX_FRAME_STATS_HIST_EN
      , .stat_hist_64(b_h0), .stat_hist_65_127(b_h1), .stat_hist_128_255(b_h2),
      .stat_hist_256_511(b_h3), .stat_hist_512_1023(b_h4), .stat_hist_1024_max(b_h5)
`endif
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int sat4(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   function automatic exp_t mk(input int g, by, f, p, r, o, h0, h1, h2, h3, h4, h5);
      exp_t e;
      e.good = g;  e.bytes = by; e.fcs = f; e.phy = p; e.runt = r; e.over = o;
      e.h0 = h0;   e.h1 = h1;    e.h2 = h2; e.h3 = h3; e.h4 = h4; e.h5 = h5;
      e.cyc = 0;
      return e;
   endfunction

   // Monitor: every published snapshot is checked against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (a_valid || b_valid)) begin
         chk("valid_match", int'(b_valid), int'(a_valid));
         if (sb.size() == 0) begin
            chk("unexpected_stat_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("good_frames", int'(a_good), e.good);
            chk("good_bytes", int'(a_bytes), e.bytes);
            chk("fcs_err", int'(a_fcs), e.fcs);
            chk("phy_err", int'(a_phy), e.phy);
            chk("runt", int'(a_runt), e.runt);
            chk("oversize", int'(a_over), e.over);
            chk("w4_good_frames", int'(b_good), sat4(e.good));
            chk("w4_good_bytes", int'(b_bytes), sat4(e.bytes));
            chk("w4_fcs_err", int'(b_fcs), sat4(e.fcs));
            chk("w4_phy_err", int'(b_phy), sat4(e.phy));
            chk("w4_runt", int'(b_runt), sat4(e.runt));
            chk("w4_oversize", int'(b_over), sat4(e.over));
`ifdef AXIS_RX_FRAME_STATS_HIST_EN
            chk("hist_64", int'(a_h0), e.h0);
            chk("hist_65_127", int'(a_h1), e.h1);
            chk("hist_128_255", int'(a_h2), e.h2);
            chk("hist_256_511", int'(a_h3), e.h3);
            chk("hist_512_1023", int'(a_h4), e.h4);
            chk("hist_1024_max", int'(a_h5), e.h5);
            chk("w4_hist_64", int'(b_h0), sat4(e.h0));
            chk("w4_hist_1024_max", int'(b_h5), sat4(e.h5));
`endif
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, int'(a_valid) + int'(b_valid), 0);
      chk({tag, "_good"}, int'(a_good) + int'(b_good), 0);
      chk({tag, "_bytes"}, int'(a_bytes) + int'(b_bytes), 0);
      chk({tag, "_fcs"}, int'(a_fcs) + int'(b_fcs), 0);
      chk({tag, "_phy"}, int'(a_phy) + int'(b_phy), 0);
      chk({tag, "_runt"}, int'(a_runt) + int'(b_runt), 0);
      chk({tag, "_over"}, int'(a_over) + int'(b_over), 0);
   endtask

   // Frame of n beats; an idle gap with tlast high is inserted periodically and must be ignored.
   task automatic frame_x(input int n, input logic [2:0] user, input bit snap,
                          input bit clr, input exp_t e);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i % 37 == 7) begin
            tvalid = 1'b0; tlast = 1'b1; tuser = 3'b011;
            @(negedge clk);
         end
         tvalid = 1'b1;
         tdata  = 8'(i);
         tlast  = (i == n - 1);
         tuser  = (i == n - 1) ? user : 3'b011;
         if (i == n - 1 && snap) begin
            snapshot = 1'b1; clear = clr;
            e.cyc = cyc + 1;
            sb.push_back(e);
         end
      end
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tuser = 3'b000; snapshot = 1'b0; clear = 1'b0;
   endtask

   task automatic frame(input int n, input logic [2:0] user);
      frame_x(n, user, 1'b0, 1'b0, e0);
   endtask

   task automatic snap(input bit clr, input exp_t e);
      @(negedge clk);
      snapshot = 1'b1; clear = clr;
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      snapshot = 1'b0; clear = 1'b0;
   endtask

   initial begin
      e0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = '0;
      snapshot = 1'b0; clear = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      frame(100, 3'b000);
      snap(1'b1, mk(1, 104, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      frame(51, 3'b000);
      frame(1596, 3'b000);
      snap(1'b1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

      frame(70, 3'b011);
      frame(70, 3'b010);
      snap(1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

      frame(1, 3'b000);
      frame(60, 3'b000);
      frame(61, 3'b000);
      frame(1514, 3'b000);
      frame(59, 3'b000);
      frame(1515, 3'b000);
      snap(1'b0, mk(3, 1647, 0, 0, 2, 1, 1, 1, 0, 0, 0, 1));
      snap(1'b1, mk(3, 1647, 0, 0, 2, 1, 1, 1, 0, 0, 0, 1));

      frame_x(100, 3'b000, 1'b1, 1'b1, mk(1, 104, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      snap(1'b0, e0);

      for (int k = 0; k < 20; k++) frame(60, 3'b000);
      snap(1'b1, mk(20, 1280, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0));

      frame(40, 3'b000);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         tvalid = 1'b1; tlast = 1'b0; tdata = 8'(i);
      end
      @(negedge clk);
      tvalid = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_zero("midframe_reset");
      @(negedge clk);
      rst_n = 1'b1;
      snap(1'b1, e0);
      frame(100, 3'b000);
      snap(1'b1, mk(1, 104, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
